// File: rtl/execute_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : execute_pkg
// Description : Opcodes, branch conditions, FSM states and branch helper for
//               the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package execute_pkg;

    localparam logic [3:0] EXE_OP_ADD = 4'd0;
    localparam logic [3:0] EXE_OP_SUB = 4'd1;
    localparam logic [3:0] EXE_OP_AND = 4'd2;
    localparam logic [3:0] EXE_OP_OR  = 4'd3;
    localparam logic [3:0] EXE_OP_XOR = 4'd4;
    localparam logic [3:0] EXE_OP_SLL = 4'd5;
    localparam logic [3:0] EXE_OP_SRL = 4'd6;
    localparam logic [3:0] EXE_OP_SRA = 4'd7;
    localparam logic [3:0] EXE_OP_ROL = 4'd8;
    localparam logic [3:0] EXE_OP_SLT = 4'd9;
    localparam logic [3:0] EXE_OP_SEQ = 4'd10;
    localparam logic [3:0] EXE_OP_MUL = 4'd11;

    localparam logic [2:0] EXE_BR_NONE = 3'd0;
    localparam logic [2:0] EXE_BR_EQZ  = 3'd1;
    localparam logic [2:0] EXE_BR_NEZ  = 3'd2;
    localparam logic [2:0] EXE_BR_LTZ  = 3'd3;
    localparam logic [2:0] EXE_BR_GEZ  = 3'd4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } exe_state_t;

    // Condition evaluated on rs only: zero flag and sign bit are enough.
    function automatic logic br_taken(input logic [2:0] br, input logic is_zero,
                                      input logic is_neg);
        logic taken;
        taken = 1'b0;
        case (br)
            EXE_BR_EQZ: taken = is_zero;
            EXE_BR_NEZ: taken = !is_zero;
            EXE_BR_LTZ: taken = is_neg;
            EXE_BR_GEZ: taken = !is_neg;
            default:    taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/execute_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : execute_pipe_if
// Description : Decode-side and memory-side handshakes of the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface execute_pipe_if #(
    parameter int DATA_W = 16
) ();
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_rs;
    logic [DATA_W-1:0] in_rt;
    logic [DATA_W-1:0] in_imm;
    logic              in_bsrc;
    logic [3:0]        in_op;
    logic [2:0]        in_br;
    logic [DATA_W-1:0] in_br_off;
    logic              in_jmp;
    logic              in_halt;
    logic              in_memwr;
    logic              in_memrd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_st_data;
    logic [DATA_W-1:0] out_pc;
    logic              out_memwr;
    logic              out_memrd;
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;
    logic              busy;

    modport master (
        output flush, in_valid, in_pc, in_rs, in_rt, in_imm, in_bsrc, in_op, in_br,
               in_br_off, in_jmp, in_halt, in_memwr, in_memrd, out_ready,
        input  in_ready, out_valid, out_alu, out_st_data, out_pc, out_memwr,
               out_memrd, redirect, redirect_pc, busy
    );

    modport slave (
        input  flush, in_valid, in_pc, in_rs, in_rt, in_imm, in_bsrc, in_op, in_br,
               in_br_off, in_jmp, in_halt, in_memwr, in_memrd, out_ready,
        output in_ready, out_valid, out_alu, out_st_data, out_pc, out_memwr,
               out_memrd, redirect, redirect_pc, busy
    );
endinterface
`default_nettype wire

// File: rtl/execute_pipe_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : exe_mul_iter
// Description : Iterative shift-add multiplier, RADIX multiplier bits per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module exe_mul_iter #(
    parameter int DATA_W = 16,
    parameter int RADIX  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int c_ITER  = DATA_W / RADIX;
    localparam int c_CNT_W = $clog2(c_ITER + 1);

    logic [DATA_W-1:0]  r_mcand;
    logic [DATA_W-1:0]  r_mplier;
    logic [DATA_W-1:0]  r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  w_mcand;
    logic [DATA_W-1:0]  w_mplier;
    logic [DATA_W-1:0]  w_acc_nxt;

    function automatic logic [DATA_W-1:0] digit_product(input logic [DATA_W-1:0] m,
                                                        input logic [RADIX-1:0] d);
        logic [DATA_W-1:0] p;
        p = '0;
        for (int i = 0; i < RADIX; i++) begin
            if (d[i]) p = p + (m << i);
        end
        return p;
    endfunction

    // The start cycle already retires the first digit, so the final digit
    // lands with the counter at zero and the product waits there.
    always_comb begin
        w_mcand   = start ? a : r_mcand;
        w_mplier  = start ? b : r_mplier;
        w_acc_nxt = (start ? '0 : r_acc) + digit_product(w_mcand, w_mplier[RADIX-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (start) begin
            r_mcand  <= a << RADIX;
            r_mplier <= b >> RADIX;
            r_acc    <= w_acc_nxt;
            r_cnt    <= c_CNT_W'(c_ITER - 1);
        end else if (r_cnt != '0) begin
            r_mcand  <= r_mcand << RADIX;
            r_mplier <= r_mplier >> RADIX;
            r_acc    <= w_acc_nxt;
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    assign done    = (r_cnt == '0);
    assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/execute_pipe.sv
`default_nettype none
// ============================================================================
// Module      : execute_pipe
// Description : Execute stage with EX/MEM register, iterative MUL, registered
//               branch/jump redirect and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_pipe #(
    parameter int DATA_W    = 16,
    parameter int MUL_EN    = 1,
    parameter int MUL_RADIX = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    execute_pipe_if.slave bus
);
    import execute_pkg::*;

    localparam int c_SH_W = $clog2(DATA_W);

    exe_state_t        r_state;
    exe_state_t        w_state_nxt;
    logic              w_busy;
    logic [DATA_W-1:0] w_b;
    logic [c_SH_W-1:0] w_sh;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_tgt;
    logic              w_redir;
    logic              w_is_mul;
    logic              w_out_free;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_mul_start;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_prod;
    logic              w_load_alu;
    logic              w_load_mul;

    logic [DATA_W-1:0] r_mul_pc;
    logic [DATA_W-1:0] r_mul_st;
    logic [DATA_W-1:0] r_mul_tgt;
    logic              r_mul_redir;
    logic              r_mul_wr;
    logic              r_mul_rd;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_alu;
    logic [DATA_W-1:0] r_out_st;
    logic [DATA_W-1:0] r_out_pc;
    logic              r_out_wr;
    logic              r_out_rd;
    logic              r_redirect;
    logic [DATA_W-1:0] r_redirect_pc;

    always_comb begin
        w_b   = bus.in_bsrc ? bus.in_imm : bus.in_rt;
        w_sh  = w_b[c_SH_W-1:0];
        w_alu = '0;
        case (bus.in_op)
            EXE_OP_ADD: w_alu = bus.in_rs + w_b;
            EXE_OP_SUB: w_alu = bus.in_rs - w_b;
            EXE_OP_AND: w_alu = bus.in_rs & w_b;
            EXE_OP_OR:  w_alu = bus.in_rs | w_b;
            EXE_OP_XOR: w_alu = bus.in_rs ^ w_b;
            EXE_OP_SLL: w_alu = bus.in_rs << w_sh;
            EXE_OP_SRL: w_alu = bus.in_rs >> w_sh;
            EXE_OP_SRA: w_alu = $signed(bus.in_rs) >>> w_sh;
            EXE_OP_ROL: w_alu = (bus.in_rs << w_sh) |
                                (bus.in_rs >> (c_SH_W + 1)'(DATA_W - int'(w_sh)));
            EXE_OP_SLT: w_alu = {{(DATA_W-1){1'b0}}, ($signed(bus.in_rs) < $signed(w_b))};
            EXE_OP_SEQ: w_alu = {{(DATA_W-1){1'b0}}, (bus.in_rs == w_b)};
            default:    w_alu = '0;
        endcase
    end

    always_comb begin
        w_redir = !bus.in_halt &&
                  (bus.in_jmp || br_taken(bus.in_br, (bus.in_rs == '0), bus.in_rs[DATA_W-1]));
        w_tgt   = bus.in_jmp ? w_alu : (bus.in_pc + bus.in_br_off);
    end

    assign w_is_mul    = (MUL_EN != 0) && (bus.in_op == EXE_OP_MUL);
    assign w_out_free  = !r_out_valid || bus.out_ready;
    assign w_in_ready  = (r_state == IDLE) && w_out_free;
    assign w_accept    = bus.in_valid && w_in_ready && !bus.flush;
    assign w_mul_start = w_accept && w_is_mul;
    assign w_load_alu  = w_accept && !w_is_mul;
    // A finished product still has to wait for the output register to drain.
    assign w_load_mul  = (r_state == MUL) && w_mul_done && w_out_free && !bus.flush;

    generate
        if (MUL_EN != 0) begin : g_mul
            exe_mul_iter #(
                .DATA_W (DATA_W),
                .RADIX  (MUL_RADIX)
            ) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (w_mul_start),
                .a       (bus.in_rs),
                .b       (w_b),
                .done    (w_mul_done),
                .product (w_mul_prod)
            );
        end else begin : g_no_mul
            assign w_mul_done = 1'b0;
            assign w_mul_prod = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mul_start) w_state_nxt = MUL;
            end
            MUL: begin
                w_busy = 1'b1;
                if (bus.flush || w_load_mul) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_pc    <= '0;
            r_mul_st    <= '0;
            r_mul_tgt   <= '0;
            r_mul_redir <= 1'b0;
            r_mul_wr    <= 1'b0;
            r_mul_rd    <= 1'b0;
        end else if (w_mul_start) begin
            r_mul_pc    <= bus.in_pc;
            r_mul_st    <= bus.in_rt;
            r_mul_tgt   <= w_tgt;
            r_mul_redir <= w_redir;
            r_mul_wr    <= bus.in_memwr;
            r_mul_rd    <= bus.in_memrd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_alu     <= '0;
            r_out_st      <= '0;
            r_out_pc      <= '0;
            r_out_wr      <= 1'b0;
            r_out_rd      <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            if (w_load_alu) begin
                r_out_alu     <= w_alu;
                r_out_st      <= bus.in_rt;
                r_out_pc      <= bus.in_pc;
                r_out_wr      <= bus.in_memwr;
                r_out_rd      <= bus.in_memrd;
                r_redirect_pc <= w_tgt;
            end else if (w_load_mul) begin
                r_out_alu     <= w_mul_prod;
                r_out_st      <= r_mul_st;
                r_out_pc      <= r_mul_pc;
                r_out_wr      <= r_mul_wr;
                r_out_rd      <= r_mul_rd;
                r_redirect_pc <= r_mul_tgt;
            end
            // Pulse only on the load edge so a stalled result never re-fires it.
            r_redirect  <= (w_load_alu && w_redir) || (w_load_mul && r_mul_redir);
            r_out_valid <= w_load_alu || w_load_mul || (r_out_valid && !bus.out_ready);
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.busy        = w_busy;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_alu     = r_out_alu;
    assign bus.out_st_data = r_out_st;
    assign bus.out_pc      = r_out_pc;
    assign bus.out_memwr   = r_out_wr;
    assign bus.out_memrd   = r_out_rd;
    assign bus.redirect    = r_redirect;
    assign bus.redirect_pc = r_redirect_pc;

endmodule
`default_nettype wire
